// File: rtl/ir_frame_decoder_pkg.sv
// Shared symbol and state types for the IR frame decoder.
package ir_frame_decoder_pkg;

  // Space classification result; SYM_STOP marks a malformed (bad) space.
  typedef enum logic [1:0] {
    SYM_STOP  = 2'b00,
    SYM_START = 2'b01,
    SYM_ZERO  = 2'b10,
    SYM_ONE   = 2'b11
  } sym_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  // Entry layout is {err, last, data}: two flag bits above the payload.
  localparam int unsigned ENT_META_W = 2;

endpackage

// File: rtl/ir_sync_fifo.sv
// Small synchronous FIFO with a registered head entry and valid flag.
module ir_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_pop;
  logic             w_push;
  logic [PW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_pop       = r_valid & pop;
  assign w_push      = push & ((r_count != DEPTH_C) | w_pop);
  assign w_rd_nxt    = r_rd_ptr + PW'(w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // The incoming word becomes the head directly when it is the only entry left.
  assign w_head_nxt  = (w_push && (w_rd_nxt == r_wr_ptr)) ? din : r_mem[w_rd_nxt];

  assign full  = (r_count == DEPTH_C);
  assign dout  = r_head;
  assign valid = r_valid;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head; head holds when the FIFO empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) r_head <= w_head_nxt;
    end
  end

endmodule

// File: rtl/ir_frame_decoder.sv
// Pulse-distance IR frame decoder: header detect, bit assembly, output FIFO.
module ir_frame_decoder
  import ir_frame_decoder_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned HDR_MARK_MIN = 39000,
  parameter int unsigned ZERO_MIN     = 2000,
  parameter int unsigned ONE_MIN      = 10000,
  parameter int unsigned TIMEOUT      = 30000,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LSB_FIRST    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned   BC_W    = $clog2(DATA_W + 1);
  localparam int unsigned   ENT_W   = DATA_W + ENT_META_W;
  localparam logic [CNT_W-1:0] SAT_C  = '1;
  localparam logic [CNT_W-1:0] HDR_C  = CNT_W'(HDR_MARK_MIN);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
  localparam logic [BC_W-1:0]  BITS_C = BC_W'(DATA_W);
  localparam logic [BC_W-1:0]  MSBP_C = BC_W'(DATA_W - 1);

  logic             r_prev;
  logic             r_hdr_seen;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sym_vld;
  sym_e             r_sym;
  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  sym_e             w_sym;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [BC_W-1:0]  r_bitcnt;
  logic [BC_W-1:0]  w_bitcnt_nxt;
  logic [BC_W-1:0]  w_bitcnt_inc;
  logic [BC_W-1:0]  w_pos;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_word_nxt;
  logic [DATA_W-1:0] w_bit_word;
  logic             w_push;
  logic [ENT_W-1:0] w_push_ent;

  logic             r_push;
  logic [ENT_W-1:0] r_push_ent;
  logic             r_overflow;
  logic             w_fifo_full;
  logic             w_fifo_valid;
  logic [ENT_W-1:0] w_fifo_dout;
  logic             w_pop;

  assign w_rise    = ~r_prev & in;
  assign w_fall    = r_prev & ~in;
  assign w_timeout = ~r_prev & ~in & (r_cnt == TMO_C);

  // Classify the space that a rising edge just terminated.
  always_comb begin
    w_sym = SYM_STOP;
    if ((r_cnt > ONE_C) && (r_cnt != SAT_C)) begin
      w_sym = r_hdr_seen ? SYM_START : SYM_ONE;
    end else if ((r_cnt > ZERO_C) && (r_cnt <= ONE_C)) begin
      w_sym = SYM_ZERO;
    end
  end

  // Edge tracking, saturating interval counter, header-mark flag, symbol stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= 1'b0;
      r_cnt      <= SAT_C;
      r_hdr_seen <= 1'b0;
      r_sym_vld  <= 1'b0;
      r_sym      <= SYM_STOP;
    end else begin
      r_prev <= in;
      if (w_rise || w_fall)   r_cnt <= '0;
      else if (r_cnt != SAT_C) r_cnt <= r_cnt + 1'b1;
      if (w_fall) r_hdr_seen <= (r_cnt >= HDR_C);
      r_sym_vld <= w_rise;
      if (w_rise) r_sym <= w_sym;
    end
  end

  assign w_bitcnt_inc = r_bitcnt + 1'b1;
  assign w_pos        = (LSB_FIRST != 0) ? r_bitcnt : (MSBP_C - r_bitcnt);
  assign w_bit_word   = r_word | (DATA_W'(r_sym == SYM_ONE) << w_pos);

  // Frame FSM: next state, word assembly and push requests.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_word_nxt   = r_word;
    w_push       = 1'b0;
    w_push_ent   = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_sym_vld && (r_sym == SYM_START)) begin
          w_state_nxt  = ST_DATA;
          w_bitcnt_nxt = '0;
          w_word_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (r_sym_vld) begin
          case (r_sym)
            SYM_START: begin
              w_push       = 1'b1;
              w_push_ent   = {(r_bitcnt != '0), 1'b1, r_word};
              w_bitcnt_nxt = '0;
              w_word_nxt   = '0;
            end
            SYM_ZERO, SYM_ONE: begin
              if (w_bitcnt_inc == BITS_C) begin
                w_push       = 1'b1;
                w_push_ent   = {1'b0, 1'b0, w_bit_word};
                w_bitcnt_nxt = '0;
                w_word_nxt   = '0;
              end else begin
                w_bitcnt_nxt = w_bitcnt_inc;
                w_word_nxt   = w_bit_word;
              end
            end
            default: begin
              w_push       = 1'b1;
              w_push_ent   = {1'b1, 1'b1, r_word};
              w_state_nxt  = ST_IDLE;
              w_bitcnt_nxt = '0;
              w_word_nxt   = '0;
            end
          endcase
        end else if (w_timeout) begin
          w_push       = 1'b1;
          w_push_ent   = {(r_bitcnt != '0), 1'b1, r_word};
          w_state_nxt  = ST_IDLE;
          w_bitcnt_nxt = '0;
          w_word_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, bit counter and word register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_word   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_word   <= w_word_nxt;
    end
  end

  // Registered push request and sticky drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_push     <= 1'b0;
      r_push_ent <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_push     <= w_push;
      r_push_ent <= w_push_ent;
      if (r_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_pop = w_fifo_valid & m_ready;

  ir_sync_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (r_push),
    .din    (r_push_ent),
    .full   (w_fifo_full),
    .pop    (m_ready),
    .dout   (w_fifo_dout),
    .valid  (w_fifo_valid)
  );

  assign {m_err, m_last, m_data} = w_fifo_dout;
  assign m_valid  = w_fifo_valid;
  assign overflow = r_overflow;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Self-checking bench: LSB-first and MSB-first decoders fed the same envelope.
module tb_ir_frame_decoder;

  localparam int CNT_W = 10;
  localparam int HDR   = 390;
  localparam int ZMIN  = 20;
  localparam int OMIN  = 100;
  localparam int TMO   = 300;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  localparam int END_TMO  = 0;
  localparam int END_BAD  = 1;
  localparam int END_HDR  = 2;
  localparam int END_NONE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_s = 1'b0;
  logic m_ready = 1'b0;
  logic [DW-1:0] dl, dm;
  logic ll, lm, el, em, vl, vm, ovl, ovm, bl, bm;

  ir_frame_decoder #(
    .CNT_W(CNT_W), .HDR_MARK_MIN(HDR), .ZERO_MIN(ZMIN), .ONE_MIN(OMIN),
    .TIMEOUT(TMO), .DATA_W(DW), .LSB_FIRST(1), .FIFO_DEPTH(DEPTH)
  ) u_lsb (
    .clk(clk), .reset_n(reset_n), .in(in_s), .m_data(dl), .m_last(ll),
    .m_err(el), .m_valid(vl), .m_ready(m_ready), .overflow(ovl), .busy(bl)
  );

  ir_frame_decoder #(
    .CNT_W(CNT_W), .HDR_MARK_MIN(HDR), .ZERO_MIN(ZMIN), .ONE_MIN(OMIN),
    .TIMEOUT(TMO), .DATA_W(DW), .LSB_FIRST(0), .FIFO_DEPTH(DEPTH)
  ) u_msb (
    .clk(clk), .reset_n(reset_n), .in(in_s), .m_data(dm), .m_last(lm),
    .m_err(em), .m_valid(vm), .m_ready(m_ready), .overflow(ovm), .busy(bm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       err;
  } ent_t;

  ent_t exp_l[$];
  ent_t exp_m[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_ovf = 1'b0;
  bit   fbits[64];
  logic [7:0] last_l = '0;
  logic [7:0] last_m = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference word: bit j of the group goes to position j (or DW-1-j).
  function automatic logic [7:0] model_word(int start, int n, bit msb);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < n; j++)
      if (fbits[start + j]) v = v | (8'h01 << (msb ? (DW - 1 - j) : j));
    return v;
  endfunction

  // With the consumer stalled, anything beyond DEPTH waiting entries is lost.
  function automatic void model_push(ent_t a, ent_t b);
    if (!m_ready && (exp_l.size() >= DEPTH)) begin
      exp_ovf = 1'b1;
    end else begin
      exp_l.push_back(a);
      exp_m.push_back(b);
    end
  endfunction

  function automatic void model_frame(int start, int nb, int ending);
    int   full;
    int   rem;
    ent_t a;
    ent_t b;
    full = nb / DW;
    rem  = nb % DW;
    for (int k = 0; k < full; k++) begin
      a.data = model_word(start + k * DW, DW, 1'b0); a.last = 1'b0; a.err = 1'b0;
      b.data = model_word(start + k * DW, DW, 1'b1); b.last = 1'b0; b.err = 1'b0;
      model_push(a, b);
    end
    if (ending != END_NONE) begin
      a.data = model_word(start + full * DW, rem, 1'b0);
      b.data = model_word(start + full * DW, rem, 1'b1);
      a.last = 1'b1;
      a.err  = (ending == END_BAD) || (rem != 0);
      b.last = a.last;
      b.err  = a.err;
      model_push(a, b);
    end
  endfunction

  task automatic mark(input int len);
    in_s = 1'b1;
    repeat (len) @(negedge clk);
  endtask

  task automatic space(input int len);
    in_s = 1'b0;
    repeat (len) @(negedge clk);
  endtask

  task automatic header();
    mark(420);
    space(204);
  endtask

  task automatic send_bits(input int start, input int nb, input bit exact);
    for (int i = start; i < start + nb; i++) begin
      mark(exact ? 53 : int'($urandom_range(25, 45)));
      if (fbits[i]) space(exact ? 156 : int'($urandom_range(115, 180)));
      else          space(exact ? 53 : int'($urandom_range(30, 80)));
    end
  endtask

  task automatic run_frame(input int nb, input int ending, input bit with_hdr);
    model_frame(0, nb, ending);
    if (with_hdr) header();
    send_bits(0, nb, 1'b0);
    case (ending)
      END_TMO: begin mark(40); space(TMO + 40); end
      END_BAD: begin mark(40); space(10); mark(40); space(60); end
      END_HDR: header();
      default: ;
    endcase
  endtask

  // Consumer-side scoreboard: every accepted head must match the model.
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      #1;
      if (vl && m_ready) begin
        if (exp_l.size() == 0) chk("spurious entry lsb", 1, 0);
        else begin
          e = exp_l.pop_front();
          chk("data lsb", dl, e.data);
          chk("last lsb", ll, e.last);
          chk("err lsb", el, e.err);
          last_l = dl;
        end
      end
      if (vm && m_ready) begin
        if (exp_m.size() == 0) chk("spurious entry msb", 1, 0);
        else begin
          e = exp_m.pop_front();
          chk("data msb", dm, e.data);
          chk("last msb", lm, e.last);
          chk("err msb", em, e.err);
          last_m = dm;
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int k;
    bit in_data;
    int nb;
    int ending;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset m_valid", {vl, vm}, 0);
    chk("reset m_data", {dl, dm}, 0);
    chk("reset m_last", {ll, lm}, 0);
    chk("reset m_err", {el, em}, 0);
    chk("reset overflow", {ovl, ovm}, 0);
    chk("reset busy", {bl, bm}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b1;
    space(50);

    // Byte decode: bits 1,0,1,1,0,0,0,0 with exact timings.
    fbits[0] = 1; fbits[1] = 0; fbits[2] = 1; fbits[3] = 1;
    for (int i = 4; i < 8; i++) fbits[i] = 0;
    model_frame(0, 8, END_NONE);
    header();
    send_bits(0, 8, 1'b1);
    mark(53);
    chk("byte lsb value", last_l, 8'h0D);
    chk("byte msb value", last_m, 8'hB0);
    chk("busy in frame", {bl, bm}, 2'b11);

    // Frame end by timeout: latency counted from the falling edge.
    model_frame(8, 0, END_TMO);
    in_s = 1'b0;
    k = 0;
    while (!vl && (k < TMO + 50)) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("timeout latency", k, TMO + 3);
    space(40);
    chk("busy after timeout", {bl, bm}, 0);

    // Partial word ended by a bad space, then ignored bits while idle.
    fbits[0] = 1; fbits[1] = 1; fbits[2] = 1;
    run_frame(3, END_BAD, 1'b1);
    chk("bad partial lsb", last_l, 8'h07);
    chk("bad partial msb", last_m, 8'hE0);
    chk("busy after bad", {bl, bm}, 0);
    fbits[0] = 1; fbits[1] = 0; fbits[2] = 1;
    send_bits(0, 3, 1'b0);
    mark(40);
    space(TMO + 40);
    chk("busy stays idle", {bl, bm}, 0);

    // Full FIFO: a pop coinciding with a push keeps the new entry.
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) fbits[i] = bit'($urandom_range(0, 1));
    model_frame(0, 32, END_NONE);
    header();
    send_bits(0, 32, 1'b0);
    send_bits(32, 8, 1'b0);
    in_s = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    model_frame(32, 8, END_NONE);
    repeat (38) @(negedge clk);
    chk("overflow on push+pop", {ovl, ovm}, 0);
    chk("full head valid", {vl, vm}, 2'b11);
    m_ready = 1'b1;
    model_frame(40, 0, END_TMO);
    space(TMO + 40);

    // Overflow: five bytes 0x01..0x05 with the consumer stalled.
    m_ready = 1'b0;
    for (int b = 0; b < 5; b++)
      for (int j = 0; j < 8; j++) fbits[b * 8 + j] = bit'(((b + 1) >> j) & 1);
    model_frame(0, 40, END_NONE);
    header();
    send_bits(0, 32, 1'b0);
    mark(40);
    repeat (5) @(negedge clk);
    chk("no overflow at four", {ovl, ovm}, 0);
    send_bits(32, 8, 1'b0);
    mark(40);
    repeat (5) @(negedge clk);
    chk("overflow lsb", ovl, exp_ovf);
    chk("overflow msb", ovm, exp_ovf);
    m_ready = 1'b1;
    model_frame(40, 0, END_TMO);
    space(TMO + 40);
    chk("overflow sticky", {ovl, ovm}, 2'b11);

    // Reset mid-frame discards the partial word.
    for (int i = 0; i < 5; i++) fbits[i] = bit'($urandom_range(0, 1));
    header();
    send_bits(0, 5, 1'b0);
    reset_n = 1'b0;
    exp_ovf = 1'b0;
    #1;
    chk("reset mid m_valid", {vl, vm}, 0);
    chk("reset mid busy", {bl, bm}, 0);
    chk("reset mid overflow", {ovl, ovm}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    space(100);
    for (int i = 0; i < 8; i++) fbits[i] = bit'($urandom_range(0, 1));
    run_frame(8, END_TMO, 1'b1);
    chk("decode after reset", last_l, 8'(model_word(0, 0, 1'b0)));

    // Randomized frames with mixed endings.
    in_data = 1'b0;
    for (int f = 0; f < 10; f++) begin
      nb = int'($urandom_range(0, 20));
      for (int i = 0; i < nb; i++) fbits[i] = bit'($urandom_range(0, 1));
      ending = (f == 9) ? END_TMO : int'($urandom_range(0, 2));
      run_frame(nb, ending, !in_data);
      in_data = (ending == END_HDR);
    end

    m_ready = 1'b1;
    repeat (50) @(negedge clk);
    chk("leftover lsb", exp_l.size(), 0);
    chk("leftover msb", exp_m.size(), 0);
    chk("final busy", {bl, bm}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
